// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ntt_pkg
// Brief    : Shared types and constants for the NTT loop sequencer: FSM state
//            enum, default address width, supported transform lengths and the
//            mapping from the length selector to log2(n).
// Revision : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  // Default coefficient address width (n up to 1024)
  localparam int NTT_ADDR_W = 10;

  // Transform length selector codes
  localparam logic [10:0] N_256  = 11'h100;
  localparam logic [10:0] N_512  = 11'h200;
  localparam logic [10:0] N_1024 = 11'h400;

  // Loop sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    RUN    = 3'd2,
    TW     = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } ntt_state_t;

  // Number of stages L = log2(n); unrecognised selectors fall back to n = 256
  function automatic logic [3:0] ntt_log2_len(input logic [10:0] param_n);
    case (param_n)
      N_1024:  return 4'd10;
      N_512:   return 4'd9;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ntt_loop_ctrl
// Brief    : Loop sequencer for the NTT datapath. Walks stage / twiddle /
//            group loops for forward (Cooley-Tukey) or inverse
//            (Gentleman-Sande) transforms of n = 256/512/1024, issues one
//            butterfly address pair per handshake, pulses the omega unit
//            controls and inserts a pipeline drain gap between stages.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_loop_ctrl
  import ntt_pkg::*;
#(
  parameter int ADDR_W     = NTT_ADDR_W,
  parameter int PIPE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       param_n,
  input  logic              fwd_ntt,
  input  logic              bf_ready,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              update_m,
  output logic [3:0]        index,
  output logic              update_omega,
  output logic              busy,
  output logic              done
);

  // Drain counter is sized for PIPE_DEPTH; kept at least one bit wide so the
  // PIPE_DEPTH = 0 build (drain state unreachable) still elaborates cleanly.
  localparam int CNT_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DRAIN_LAST = CNT_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ONE_A     = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_ONE_N     = (ADDR_W + 1)'(1);

  ntt_state_t        r_state;
  logic [3:0]        r_len;     // L = log2(n), latched at start
  logic              r_fwd;     // direction, latched at start
  logic [3:0]        r_s;       // stage counter
  logic [ADDR_W-1:0] r_j;       // twiddle (outer) loop counter
  logic [ADDR_W-1:0] r_k;       // group (inner) loop base
  logic [ADDR_W-1:0] r_h;       // half-length of the current stage
  logic [CNT_W-1:0]  r_cnt;     // drain cycle counter

  logic [3:0]        w_len_start;
  logic [ADDR_W-1:0] w_h_start;
  logic [ADDR_W:0]   w_n;
  logic [ADDR_W:0]   w_k_next;
  logic [ADDR_W-1:0] w_k_next_a;
  logic [ADDR_W-1:0] w_h_next;
  logic              w_last_k;
  logic              w_last_j;
  logic              w_last_stage;

  // Loop bookkeeping: k steps by 2h and is one bit wider so k+2h = n does
  // not wrap before the end-of-group compare.
  always_comb begin
    w_len_start  = ntt_log2_len(param_n);
    w_h_start    = fwd_ntt ? C_ONE_A : (C_ONE_A << (w_len_start - 4'd1));
    w_n          = C_ONE_N << r_len;
    w_k_next     = {1'b0, r_k} + {r_h, 1'b0};
    w_k_next_a   = w_k_next[ADDR_W-1:0];
    w_h_next     = r_fwd ? (r_h << 1) : (r_h >> 1);
    w_last_k     = (w_k_next >= w_n);
    w_last_j     = (r_j == (r_h - C_ONE_A));
    w_last_stage = (r_s == (r_len - 4'd1));
  end

  // Sequencer FSM with loop counters and registered outputs; each transition
  // also loads the outputs that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_len        <= 4'd0;
      r_fwd        <= 1'b0;
      r_s          <= 4'd0;
      r_j          <= '0;
      r_k          <= '0;
      r_h          <= '0;
      r_cnt        <= '0;
      bf_valid     <= 1'b0;
      addr_a       <= '0;
      addr_b       <= '0;
      update_m     <= 1'b0;
      index        <= 4'd0;
      update_omega <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len    <= w_len_start;
            r_fwd    <= fwd_ntt;
            r_s      <= 4'd0;
            r_j      <= '0;
            r_k      <= '0;
            r_h      <= w_h_start;
            r_cnt    <= '0;
            index    <= 4'd0;
            update_m <= 1'b1;
            busy     <= 1'b1;
            r_state  <= LOAD_M;
          end
        end

        LOAD_M: begin
          update_m <= 1'b0;
          bf_valid <= 1'b1;
          addr_a   <= r_k + r_j;
          addr_b   <= r_k + r_j + r_h;
          r_state  <= RUN;
        end

        RUN: begin
          if (bf_ready) begin
            if (!w_last_k) begin
              // next group with the same twiddle
              r_k    <= w_k_next_a;
              addr_a <= w_k_next_a + r_j;
              addr_b <= w_k_next_a + r_j + r_h;
            end else begin
              bf_valid <= 1'b0;
              r_k      <= '0;
              if (!w_last_j) begin
                r_j          <= r_j + C_ONE_A;
                update_omega <= 1'b1;
                r_state      <= TW;
              end else if (PIPE_DEPTH > 0) begin
                r_cnt   <= '0;
                r_state <= DRAIN;
              end else if (!w_last_stage) begin
                r_s      <= r_s + 4'd1;
                index    <= r_s + 4'd1;
                r_h      <= w_h_next;
                r_j      <= '0;
                update_m <= 1'b1;
                r_state  <= LOAD_M;
              end else begin
                done    <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end

        TW: begin
          update_omega <= 1'b0;
          bf_valid     <= 1'b1;
          addr_a       <= r_k + r_j;
          addr_b       <= r_k + r_j + r_h;
          r_state      <= RUN;
        end

        DRAIN: begin
          if (r_cnt == C_DRAIN_LAST) begin
            if (!w_last_stage) begin
              r_s      <= r_s + 4'd1;
              index    <= r_s + 4'd1;
              r_h      <= w_h_next;
              r_j      <= '0;
              r_k      <= '0;
              update_m <= 1'b1;
              r_state  <= LOAD_M;
            end else begin
              done    <= 1'b1;
              r_state <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_loop_ctrl
// Brief    : Self-checking bench for ntt_loop_ctrl. Two instances (drain of 4
//            and drain of 0) are compared against a loop-level reference of
//            the NTT address sequence and cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_loop_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [10:0]       param_n = 11'h0;
  logic              fwd_ntt = 1'b0;
  logic              bf_ready = 1'b0;
  bit                cur_sel = 1'b0;   // 0: PIPE_DEPTH=4 instance, 1: PIPE_DEPTH=0

  logic              start4, start0;
  logic              v4, m4, o4, busy4, done4;
  logic              v0, m0, o0, busy0, done0;
  logic [ADDR_W-1:0] a4, b4, a0, b0;
  logic [3:0]        i4, i0;

  logic              obs_valid, obs_m, obs_om, obs_busy, obs_done;
  logic [ADDR_W-1:0] obs_a, obs_b;
  logic [3:0]        obs_idx;

  assign start4    = start & ~cur_sel;
  assign start0    = start & cur_sel;
  assign obs_valid = cur_sel ? v0 : v4;
  assign obs_m     = cur_sel ? m0 : m4;
  assign obs_om    = cur_sel ? o0 : o4;
  assign obs_busy  = cur_sel ? busy0 : busy4;
  assign obs_done  = cur_sel ? done0 : done4;
  assign obs_a     = cur_sel ? a0 : a4;
  assign obs_b     = cur_sel ? b0 : b4;
  assign obs_idx   = cur_sel ? i0 : i4;

  ntt_loop_ctrl #(.ADDR_W(ADDR_W), .PIPE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .param_n(param_n), .fwd_ntt(fwd_ntt),
    .bf_ready(bf_ready), .bf_valid(v4), .addr_a(a4), .addr_b(b4), .update_m(m4),
    .index(i4), .update_omega(o4), .busy(busy4), .done(done4)
  );

  ntt_loop_ctrl #(.ADDR_W(ADDR_W), .PIPE_DEPTH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .param_n(param_n), .fwd_ntt(fwd_ntt),
    .bf_ready(bf_ready), .bf_valid(v0), .addr_a(a0), .addr_b(b0), .update_m(m0),
    .index(i0), .update_omega(o0), .busy(busy0), .done(done0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model results
  int q_exp[$];
  int exp_n, exp_len, exp_omega;
  // observations of one transform
  int q_obs[$];
  int q_idx[$];
  int n_om, done_cyc, stalls, excl_err, hold_err, busy_err, first_bad;
  bit timeout, post_busy, post_done;

  function automatic int pack(input int s, input int a, input int b);
    return s * (1 << 22) + a * (1 << 11) + b;
  endfunction

  // Reference: the textbook triple loop over stages, twiddles and groups.
  task automatic build_model(input int pn, input bit fw);
    int h;
    q_exp.delete();
    exp_n     = (pn == 1024) ? 1024 : ((pn == 512) ? 512 : 256);
    exp_len   = $clog2(exp_n);
    exp_omega = 0;
    for (int s = 0; s < exp_len; s++) begin
      h = fw ? (1 << s) : (1 << (exp_len - 1 - s));
      exp_omega += h - 1;
      for (int j = 0; j < h; j++)
        for (int k = 0; k < exp_n; k += 2 * h)
          q_exp.push_back(pack(s, k + j, k + j + h));
    end
  endtask

  function automatic int exp_done(input int p, input int st);
    return 1 + exp_len * exp_n / 2 + exp_n - 1 + exp_len * p + st;
  endfunction

  function automatic int pair_mismatches();
    int m;
    m = (q_obs.size() != q_exp.size()) ? 1 : 0;
    first_bad = -1;
    for (int i = 0; i < q_obs.size() && i < q_exp.size(); i++)
      if (q_obs[i] != q_exp[i]) begin
        if (first_bad < 0) first_bad = i;
        m++;
      end
    return m;
  endfunction

  // Runs one transform; mode 0 ready=1, 1 random ready, 2 three stall cycles
  // after the 100th accept, 3 start pulse + parameter change mid-run.
  task automatic run_xfer(input bit dsel, input int pn, input bit fw, input int mode);
    int cyc, acc, stall_left, pa, pb;
    bit armed, prev_stall;
    q_obs.delete(); q_idx.delete();
    n_om = 0; done_cyc = -1; stalls = 0; excl_err = 0; hold_err = 0; busy_err = 0;
    timeout = 0; cyc = 0; acc = 0; stall_left = 0; pa = 0; pb = 0;
    armed = (mode == 2); prev_stall = 0;
    cur_sel = dsel;
    @(negedge clk);
    param_n = pn[10:0]; fwd_ntt = fw; bf_ready = 1'b1; start = 1'b1;
    while (done_cyc < 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (mode == 3 && cyc == 50) begin
        start = 1'b1; param_n = (pn == 1024) ? 11'h100 : 11'h400; fwd_ntt = ~fw;
      end
      if (mode == 3 && cyc == 51) start = 1'b0;
      if (int'(obs_valid) + int'(obs_m) + int'(obs_om) > 1) excl_err++;
      if (!obs_busy) busy_err++;
      if (obs_m) q_idx.push_back(int'(obs_idx));
      if (obs_om) n_om++;
      if (prev_stall && (!obs_valid || int'(obs_a) != pa || int'(obs_b) != pb)) hold_err++;
      if (obs_done) done_cyc = cyc;
      bf_ready = 1'b1;
      if (mode == 1) bf_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && stall_left > 0 && obs_valid) begin
        bf_ready = 1'b0; stall_left--;
      end
      prev_stall = obs_valid && !bf_ready;
      if (prev_stall) stalls++;
      if (obs_valid && bf_ready) begin
        q_obs.push_back(pack(int'(obs_idx), int'(obs_a), int'(obs_b)));
        acc++;
        if (armed && acc == 100) begin stall_left = 3; armed = 0; end
      end
      pa = int'(obs_a); pb = int'(obs_b);
    end
    if (done_cyc < 0) timeout = 1;
    @(negedge clk);
    post_busy = obs_busy; post_done = obs_done; bf_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({v4, a4, b4, m4, i4, o4, busy4, done4} !== '0) begin
      errors++; $display("FAIL reset_dut4: got %h expected 0", {v4, a4, b4, m4, i4, o4, busy4, done4});
    end
    checks++;
    if ({v0, a0, b0, m0, i0, o0, busy0, done0} !== '0) begin
      errors++; $display("FAIL reset_dut0: got %h expected 0", {v0, a0, b0, m0, i0, o0, busy0, done0});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fwd_256();
    int bad;
    build_model(256, 1);
    run_xfer(0, 256, 1, 0);
    checks++; if (timeout) begin errors++; $display("FAIL fwd256_timeout: got no done expected done"); end
    checks++; bad = pair_mismatches();
    if (bad != 0) begin errors++; $display("FAIL fwd256_pairs: got %0d bad (first %0d) expected 0", bad, first_bad); end
    checks++; if (q_obs.size() < 128 || q_obs[0] != pack(0, 0, 1) || q_obs[127] != pack(0, 254, 255)) begin
      errors++; $display("FAIL fwd256_stage0: got size %0d expected (0,1)..(254,255)", q_obs.size()); end
    checks++; if (q_obs.size() != 1024) begin errors++; $display("FAIL fwd256_accepts: got %0d expected 1024", q_obs.size()); end
    checks++; if (q_idx.size() != 8) begin errors++; $display("FAIL fwd256_update_m: got %0d expected 8", q_idx.size()); end
    bad = 0; foreach (q_idx[i]) if (q_idx[i] != i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fwd256_index: got %0d wrong expected 0", bad); end
    checks++; if (n_om != 247) begin errors++; $display("FAIL fwd256_omega: got %0d expected 247", n_om); end
    checks++; if (done_cyc != 1312) begin errors++; $display("FAIL fwd256_done: got %0d expected 1312", done_cyc); end
    checks++; if (excl_err != 0 || busy_err != 0) begin
      errors++; $display("FAIL fwd256_excl_busy: got %0d/%0d expected 0/0", excl_err, busy_err); end
    checks++; if (post_busy || post_done) begin
      errors++; $display("FAIL fwd256_after_done: got busy=%0d done=%0d expected 0/0", post_busy, post_done); end
  endtask

  task automatic test_inv_1024();
    int bad;
    build_model(1024, 0);
    run_xfer(0, 1024, 0, 0);
    checks++; bad = pair_mismatches();
    if (bad != 0) begin errors++; $display("FAIL inv1024_pairs: got %0d bad (first %0d) expected 0", bad, first_bad); end
    checks++; if (q_obs.size() != 5120) begin errors++; $display("FAIL inv1024_accepts: got %0d expected 5120", q_obs.size()); end
    checks++; if (q_obs.size() != 5120 || q_obs[0] != pack(0, 0, 512) || q_obs[1] != pack(0, 1, 513)
                  || q_obs[5119] != pack(9, 1022, 1023)) begin
      errors++; $display("FAIL inv1024_endpoints: got size %0d expected (0,512),(1,513)..(1022,1023)", q_obs.size()); end
    bad = (q_idx.size() != 10) ? 1 : 0; foreach (q_idx[i]) if (q_idx[i] != i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL inv1024_index: got %0d wrong expected 0", bad); end
    checks++; if (done_cyc != exp_done(4, 0)) begin
      errors++; $display("FAIL inv1024_done: got %0d expected %0d", done_cyc, exp_done(4, 0)); end
    checks++; if (n_om != exp_omega || excl_err != 0) begin
      errors++; $display("FAIL inv1024_omega: got %0d/%0d expected %0d/0", n_om, excl_err, exp_omega); end
  endtask

  task automatic test_no_drain_512();
    int bad;
    build_model(512, 1);
    run_xfer(1, 512, 1, 0);
    checks++; bad = pair_mismatches();
    if (bad != 0) begin errors++; $display("FAIL nodrain_pairs: got %0d bad (first %0d) expected 0", bad, first_bad); end
    checks++; if (q_obs.size() != 2304) begin errors++; $display("FAIL nodrain_accepts: got %0d expected 2304", q_obs.size()); end
    checks++; if (n_om != 502) begin errors++; $display("FAIL nodrain_omega: got %0d expected 502", n_om); end
    checks++; if (done_cyc != 2816) begin errors++; $display("FAIL nodrain_done: got %0d expected 2816", done_cyc); end
    checks++; if (excl_err != 0 || busy_err != 0 || post_busy) begin
      errors++; $display("FAIL nodrain_flags: got %0d/%0d/%0d expected 0/0/0", excl_err, busy_err, post_busy); end
  endtask

  task automatic test_stall();
    int bad;
    build_model(256, 1);
    run_xfer(0, 256, 1, 2);
    checks++; if (stalls != 3 || hold_err != 0) begin
      errors++; $display("FAIL stall_hold: got stalls=%0d hold_err=%0d expected 3/0", stalls, hold_err); end
    checks++; if (done_cyc != 1315) begin errors++; $display("FAIL stall_done: got %0d expected 1315", done_cyc); end
    checks++; bad = pair_mismatches();
    if (bad != 0 || excl_err != 0) begin
      errors++; $display("FAIL stall_pairs: got %0d bad excl=%0d expected 0/0", bad, excl_err); end
  endtask

  task automatic test_ignore_start();
    int bad;
    build_model(256, 1);
    run_xfer(0, 256, 1, 3);
    checks++; bad = pair_mismatches();
    if (bad != 0) begin errors++; $display("FAIL ignore_pairs: got %0d bad (first %0d) expected 0", bad, first_bad); end
    checks++; if (done_cyc != 1312 || q_idx.size() != 8) begin
      errors++; $display("FAIL ignore_done: got %0d/%0d expected 1312/8", done_cyc, q_idx.size()); end
  endtask

  task automatic test_random();
    int pn_tab[4] = '{256, 512, 1024, 'h123};
    int pn, bad, p;
    bit fw, sel;
    for (int it = 0; it < 3; it++) begin
      pn  = pn_tab[$urandom_range(0, 3)];
      fw  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      p   = sel ? 0 : 4;
      build_model(pn, fw);
      run_xfer(sel, pn, fw, 1);
      checks++; bad = pair_mismatches();
      if (bad != 0) begin errors++; $display("FAIL rand%0d_pairs: got %0d bad (first %0d) expected 0", it, bad, first_bad); end
      checks++; if (done_cyc != exp_done(p, stalls)) begin
        errors++; $display("FAIL rand%0d_done: got %0d expected %0d", it, done_cyc, exp_done(p, stalls)); end
      checks++; if (n_om != exp_omega || hold_err != 0 || excl_err != 0) begin
        errors++; $display("FAIL rand%0d_ctrl: got omega=%0d hold=%0d excl=%0d expected %0d/0/0",
                           it, n_om, hold_err, excl_err, exp_omega); end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bad;
    cur_sel = 1'b0;
    @(negedge clk); param_n = 11'h100; fwd_ntt = 1'b1; bf_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(v4 && i4 == 4'd3) && cyc < 5000) begin @(negedge clk); cyc++; end
    checks++; if (!(v4 && i4 == 4'd3)) begin
      errors++; $display("FAIL midrst_reach: got index %0d expected 3", i4); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({v4, a4, b4, m4, i4, o4, busy4, done4} !== '0) begin
      errors++; $display("FAIL midrst_async: got %h expected 0", {v4, a4, b4, m4, i4, o4, busy4, done4}); end
    @(negedge clk); rst_n = 1'b1;
    build_model(256, 1);
    run_xfer(0, 256, 1, 0);
    checks++; bad = pair_mismatches();
    if (bad != 0 || done_cyc != 1312) begin
      errors++; $display("FAIL midrst_replay: got %0d bad done=%0d expected 0/1312", bad, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_fwd_256();
    test_inv_1024();
    test_no_drain_512();
    test_stall();
    test_ignore_start();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_loop_ctrl.md
Name: ntt_loop_ctrl

Overview:
- Loop sequencer for the NTT datapath. It walks the stage/twiddle/group loops of a forward (Cooley-Tukey) or inverse (Gentleman-Sande) NTT for n = 256/512/1024.
- Upstream of the omega update unit: drives its update_m, index and update_omega controls.
- Issues one butterfly address pair per accepted handshake to the butterfly/memory stage.
- Inserts a drain gap between stages so pipelined write-back completes before the next stage reads.

Parameters:
- ADDR_W, 10, width of the coefficient address (supports n up to 1024).
- PIPE_DEPTH, 4, drain cycles inserted after the last butterfly of each stage (0 = no drain).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform; honoured only in IDLE.
- param_n  in  11  transform length: 0x400 = 1024, 0x200 = 512, any other value = 256. Sampled at start.
- fwd_ntt  in  1  1 = forward, 0 = inverse. Sampled at start.
- bf_ready  in  1  downstream accepts the current butterfly.
- bf_valid  out  1  addr_a/addr_b hold a valid butterfly.
- addr_a  out  ADDR_W  lower coefficient address (k+j).
- addr_b  out  ADDR_W  upper coefficient address (k+j+h).
- update_m  out  1  one-cycle pulse at stage start, to the omega unit.
- index  out  4  stage number s, to the omega unit.
- update_omega  out  1  one-cycle pulse advancing the twiddle, to the omega unit.
- busy  out  1  high from LOAD_M through DONE inclusive.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low (clk, rst_n). Every register clears on rst_n low, independent of clk.
- Reset values: all outputs 0; state = IDLE; counters 0.
- Loop definition:
  - L = log2(n) (8/9/10). Stage s = 0..L-1.
  - Half-length h = 2^s when forward, 2^(L-1-s) when inverse.
  - For each j = 0..h-1 (outer), for each k = 0, 2h, 4h, ... < n (inner): addr_a = k+j, addr_b = k+j+h.
- index = s, registered. Stable from the LOAD_M cycle through the end of that stage's DRAIN.
- IDLE: start=1 latches param_n and fwd_ntt, clears s/j/k, goes to LOAD_M.
- LOAD_M (1 cycle): update_m=1, bf_valid=0. Go to RUN.
- RUN: bf_valid=1 with the current addresses.
  - bf_ready=0: hold the state and keep addresses stable.
  - On accept (bf_valid & bf_ready), advance k.
  - Accept of last k with j<h-1: j++, k=0, go to TW.
  - Accept of last k with j=h-1: go to DRAIN (or straight to the next step below if PIPE_DEPTH=0).
- TW (1 cycle): update_omega=1, bf_valid=0. Go to RUN. The omega unit output is valid in that RUN cycle.
- DRAIN: count PIPE_DEPTH cycles with bf_valid=0. Then if s<L-1: s++, go to LOAD_M; else go to DONE.
- DONE (1 cycle): done=1, busy=1. Go to IDLE.
- update_m, update_omega and bf_valid are mutually exclusive in every cycle. No twiddle pulse occurs in any stage with h=1.
- Latency with bf_ready tied 1, first LOAD_M cycle = cycle 1:
  - Stage cost = n/2 + h + PIPE_DEPTH cycles.
  - done is high in cycle 1 + (L*n/2 + n-1 + L*PIPE_DEPTH).
  - Each bf_ready=0 cycle during RUN adds exactly one cycle.
- start while busy is ignored. param_n/fwd_ntt changes after start have no effect until the next start.
- Counter widths: k and j use ADDR_W bits, s uses 4 bits. No wrap-around occurs for legal n; last addresses are 1022/1023 for n=1024.
- Reset mid-operation aborts immediately. The next start replays the full sequence from s=0.

Decomposition:
- Shared package ntt_pkg holds:
  - state enum {IDLE, LOAD_M, RUN, TW, DRAIN, DONE};
  - the ADDR_W default;
  - constants N_256/N_512/N_1024 (11'h100/200/400);
  - a function mapping param_n to L.
- No sub-module is needed. The loop counters stay inline in the FSM (about 200 lines).

Test Plan:
- n=256 fwd, bf_ready=1, PIPE_DEPTH=4 -> stage 0 pairs (0,1),(2,3)..(254,255); 1024 accepts; 8 update_m; 247 update_omega; index 0..7; done in cycle 1312.
- n=1024 inv, bf_ready=1 -> stage 0 (h=512) sequence (0,512), TW, (1,513), ...; last stage pairs (0,1)..(1022,1023); 5120 accepts; index 0..9.
- n=512 fwd, PIPE_DEPTH=0 -> no DRAIN cycles; 2304 accepts; 502 update_omega; done in cycle 2816.
- bf_ready=0 for 3 cycles mid-RUN -> bf_valid held, addr_a/addr_b unchanged, no pulses; done 3 cycles later than baseline.
- start pulsed while busy, and param_n changed mid-run -> both ignored; sequence identical to baseline.
- rst_n low mid-stage 3 -> all outputs 0 without a clock edge; a new start reproduces the baseline sequence exactly.
